// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline control unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    STALLED = 2'd1,
    FLUSH   = 2'd2
  } pipe_ctrl_state_e;

  // Stall masks, bit0 PC .. bit5 WB; a stage stops together with everything upstream of it.
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;

  localparam logic [31:0] EXC_ERET = 32'h0000_000E;
  localparam logic [31:0] EXC_WDOG = 32'h0000_00FF;

endpackage

// File: rtl/pipe_ctrl_stats.sv
// Stall/flush statistics: run counter, stalled-cycle count, flush count, longest stall run.
// Latency: counters reflect a strobe one cycle after it is presented.
// Backpressure: none; strobes are sampled every cycle.
module pipe_ctrl_stats (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_stall_vld,
  input  logic        i_flush,
  output logic [15:0] o_run_cnt,
  output logic [31:0] o_stall_cycles,
  output logic [15:0] o_flush_cnt,
  output logic [15:0] o_max_stall_run
);

  logic [15:0] run_inc;

  // Length of the run including the current stalled cycle, saturating.
  assign run_inc = (o_run_cnt == 16'hFFFF) ? 16'hFFFF : o_run_cnt + 16'd1;

  // Run counter and longest-run tracker; any non-stalled cycle (including flush) ends the run.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_run_cnt       <= 16'd0;
      o_max_stall_run <= 16'd0;
    end else if (i_stall_vld) begin
      o_run_cnt <= run_inc;
      if (run_inc > o_max_stall_run) o_max_stall_run <= run_inc;
    end else begin
      o_run_cnt <= 16'd0;
    end
  end

  // Saturating count of stalled cycles.
  always_ff @(posedge i_clk) begin
    if (i_rst)
      o_stall_cycles <= 32'd0;
    else if (i_stall_vld && (o_stall_cycles != 32'hFFFF_FFFF))
      o_stall_cycles <= o_stall_cycles + 32'd1;
  end

  // Wrapping count of flushes.
  always_ff @(posedge i_clk) begin
    if (i_rst)
      o_flush_cnt <= 16'd0;
    else if (i_flush)
      o_flush_cnt <= o_flush_cnt + 16'd1;
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: stall vector, flush and redirect PC; optional watchdog via PIPE_CTRL_WDOG_EN.
// Latency: o_stall/o_flush/o_new_pc are combinational (same cycle); stats/flags one cycle later.
// Backpressure: none; it is the source of pipeline backpressure, and the cycle after a flush is masked.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
  parameter int unsigned WDOG_LIMIT = 1024
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_stallreq_id,
  input  logic        i_stallreq_ex,
  input  logic        i_stallreq_mem,
  input  logic [31:0] i_except_type,
  input  logic [31:0] i_cp0_epc,
  output logic [5:0]  o_stall,
  output logic        o_flush,
  output logic [31:0] o_new_pc,
  output logic [31:0] o_stall_cycles,
  output logic [15:0] o_flush_cnt,
  output logic [15:0] o_max_stall_run,
  output logic [31:0] o_last_exc,
  output logic        o_wdog_timeout
);

  localparam logic [1:0] ST_RUN     = RUN;
  localparam logic [1:0] ST_STALLED = STALLED;
  localparam logic [1:0] ST_FLUSH   = FLUSH;

  // Run-counter value at which a still-stalled pipeline is declared hung.
  localparam logic [15:0] WDOG_TRIP = 16'(WDOG_LIMIT - 1);

  logic [1:0]  state_q;
  logic [1:0]  state_nxt;
  logic [15:0] run_cnt;
  logic        wdog_hit;
  logic        wdog_fire;
  logic [31:0] exc_code;

`ifdef PIPE_CTRL_WDOG_EN
  assign wdog_hit = (run_cnt == WDOG_TRIP);
`else
  // Watchdog not built: never fires, flag tied low.
  assign wdog_hit = 1'b0 && (run_cnt == WDOG_TRIP);
`endif

  // Arbitration: exception > watchdog > MEM > EX > ID; FLUSH masks everything for one cycle.
  always_comb begin
    o_stall   = STALL_NONE;
    o_flush   = 1'b0;
    o_new_pc  = 32'd0;
    exc_code  = 32'd0;
    wdog_fire = 1'b0;
    state_nxt = ST_RUN;
    if (!i_rst && (state_q != ST_FLUSH)) begin
      if (i_except_type != 32'd0) begin
        o_flush   = 1'b1;
        o_new_pc  = (i_except_type == EXC_ERET) ? i_cp0_epc : EXC_VECTOR;
        exc_code  = i_except_type;
        state_nxt = ST_FLUSH;
      end else if (i_stallreq_mem || i_stallreq_ex || i_stallreq_id) begin
        if (wdog_hit) begin
          o_flush   = 1'b1;
          o_new_pc  = EXC_VECTOR;
          exc_code  = EXC_WDOG;
          wdog_fire = 1'b1;
          state_nxt = ST_FLUSH;
        end else begin
          if (i_stallreq_mem)     o_stall = STALL_MEM;
          else if (i_stallreq_ex) o_stall = STALL_EX;
          else                    o_stall = STALL_ID;
          state_nxt = ST_STALLED;
        end
      end
    end
  end

  // State register and last-exception latch.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_RUN;
      o_last_exc <= 32'd0;
    end else begin
      state_q <= state_nxt;
      if (o_flush) o_last_exc <= exc_code;
    end
  end

`ifdef PIPE_CTRL_WDOG_EN
  // Sticky timeout flag, cleared only by reset.
  always_ff @(posedge i_clk) begin
    if (i_rst)          o_wdog_timeout <= 1'b0;
    else if (wdog_fire) o_wdog_timeout <= 1'b1;
  end
`else
  assign o_wdog_timeout = 1'b0;
`endif

  pipe_ctrl_stats u_stats (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_stall_vld     (o_stall != STALL_NONE),
    .i_flush         (o_flush),
    .o_run_cnt       (run_cnt),
    .o_stall_cycles  (o_stall_cycles),
    .o_flush_cnt     (o_flush_cnt),
    .o_max_stall_run (o_max_stall_run)
  );

endmodule
